tone_mixer: RTL and testbench
=============================

# tone_mixer

Parametrised multi-channel square-wave tone generator and stereo mixer for the audio path. Each channel divides `clk` by a programmable half-period to form a square wave that gates its own amplitude word. Each channel routes to the left and/or right bus, and each bus is summed with saturation into registered 16-bit-style sample outputs. It sits between the note/sequencer logic and the audio codec serialiser, and replaces the single-tone buzzer stage.

## Interface
- `CHANNELS`, default 4: number of independent tone channels (1..8).
- `DIV_W`, default 20: width of each half-period divisor.
- `AMP_W`, default 16: width of each amplitude word and of each output sample.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `note_div`  in  CHANNELS*DIV_W  per-channel half-period minus 1; channel i occupies `[i*DIV_W +: DIV_W]`; 0 = channel silent.
- `amp`  in  CHANNELS*AMP_W  per-channel unsigned amplitude; channel i occupies `[i*AMP_W +: AMP_W]`.
- `ch_en`  in  CHANNELS  per-channel enable.
- `left_mask`  in  CHANNELS  bit i routes channel i to the left bus.
- `right_mask`  in  CHANNELS  bit i routes channel i to the right bus.
- `sync`  in  1  synchronous phase restart of all channels.
- `audio_left`  out  AMP_W  registered left sample.
- `audio_right`  out  AMP_W  registered right sample.
- `clip_left`  out  1  registered; left sum saturated this sample.
- `clip_right`  out  1  registered; right sum saturated this sample.

## Operation
- Per-channel state: counter `cnt` (DIV_W bits), latched divisor `dl` (DIV_W bits), phase bit `ph`.
- Per-channel update each `clk` edge, evaluated in priority order:
  - `sync` = 1: `cnt` <= 0, `ph` <= 0, `dl` <= note_div_i.
  - `dl` == 0: `cnt` <= 0, `ph` <= 0, `dl` <= note_div_i. A zero divisor reloads every cycle, so a new nonzero value is picked up immediately.
  - `cnt` == `dl`: `cnt` <= 0, `ph` <= ~`ph`, `dl` <= note_div_i. A divisor change therefore takes effect only at a half-period boundary, which keeps the waveform glitch-free.
  - otherwise: `cnt` <= `cnt` + 1.
- Contribution: c_i = amp_i when `ch_en_i` && `dl` != 0 && `ph` == 0; otherwise c_i = 0.
  - `amp` is sampled live every cycle and is not latched.
  - `ch_en` does not stop the counter; the phase keeps running while a channel is disabled.
- Mixing:
  - sumL = Σ c_i·left_mask_i and sumR = Σ c_i·right_mask_i.
  - Both sums are computed at AMP_W + clog2(CHANNELS) bits with no overflow.
  - Saturation: if sum > 2^AMP_W − 1, the output is 2^AMP_W − 1 and the clip flag is 1; otherwise the output is the sum and the clip flag is 0.
- All four outputs are registered from the current-state contributions.

## Timing
- Reset (asynchronous) clears everything to 0: all `cnt`, `dl`, `ph`, `audio_left`, `audio_right`, `clip_left`, `clip_right`. A mid-operation reset zeroes the outputs immediately, with no clock needed.
- Startup with a constant divisor D > 0, counting edges after reset release as E1, E2, …:
  - E1: `dl` loads D; outputs stay 0.
  - E2: outputs first show amp.
  - amp is held for D+1 cycles, then 0 for D+1 cycles.
  - Period is 2(D+1) cycles.
- Output latency: 1 cycle from any change of channel state, `amp`, `ch_en` or mask to the corresponding output.
- `sync`: the edge that samples `sync` = 1 sets `ph` = 0. High output (if enabled) appears one edge later. All channels are then phase-aligned.
- Simultaneous `sync` and terminal count: `sync` wins, with no toggle.
- Counter wrap: `cnt` never exceeds `dl`. The maximum divisor 2^DIV_W − 1 gives a half-period of 2^DIV_W cycles.

## Test plan
- Single channel, CHANNELS=4, ch0 note_div=3, amp=0x1000, ch_en=0001, left_mask=0001, right_mask=0000:
  - left = 0x1000 from E2 for 4 cycles, then 0x0000 for 4 cycles, repeating.
  - right stays 0; no clips.
- Saturation: ch0 and ch1 both note_div=5, amp=0xC000, both routed left, `sync` pulsed:
  - left = 0xFFFF with clip_left=1 during the high phase.
  - 0x0000 with clip_left=0 during the low phase.
- Divisor change mid half-period: ch0 note_div 9→2 applied at cnt=4 of a high phase.
  - The current half-period completes at 10 cycles; subsequent half-periods are 3 cycles.
- Zero/enable:
  - note_div=0: output 0 indefinitely.
  - note_div set to 1: output high 2 cycles after the change, then 2/2 toggling.
  - Dropping ch_en for 3 cycles zeroes the contribution 1 cycle later, and the phase continues unchanged on re-enable.
- Reset mid-tone: assert rst_n=0 while left=0x1000.
  - Outputs are 0 asynchronously.
  - After release, the startup sequence repeats exactly as from a cold reset.

Source files
------------

// File: rtl/tone_mixer.sv
// -----------------------------------------------------------------------------
// tone_mixer
// Multi-channel square-wave tone generator with a saturating stereo mixer.
// Each channel divides clk by a programmable half-period. The resulting square
// wave gates that channel's amplitude word. Gated words are routed to the
// left and/or right bus, summed, and then clipped to the AMP_W range.
//
// Parameters
//   CHANNELS    number of tone channels (1..8)
//   DIV_W       half-period divisor width
//   AMP_W       amplitude / output sample width
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   note_div    per-channel half-period minus 1 (0 = silent), DIV_W each
//   amp         per-channel unsigned amplitude, AMP_W each (sampled live)
//   ch_en       per-channel enable (gates output only, phase keeps running)
//   left_mask   per-channel routing to the left bus
//   right_mask  per-channel routing to the right bus
//   sync        synchronous phase restart of all channels
//   audio_left  registered left sample
//   audio_right registered right sample
//   clip_left   registered, left sum saturated this sample
//   clip_right  registered, right sum saturated this sample
// -----------------------------------------------------------------------------
module tone_mixer #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DIV_W    = 20,
   parameter int unsigned AMP_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*DIV_W-1:0] note_div,
   input  logic [CHANNELS*AMP_W-1:0] amp,
   input  logic [CHANNELS-1:0]       ch_en,
   input  logic [CHANNELS-1:0]       left_mask,
   input  logic [CHANNELS-1:0]       right_mask,
   input  logic                      sync,
   output logic [AMP_W-1:0]          audio_left,
   output logic [AMP_W-1:0]          audio_right,
   output logic                      clip_left,
   output logic                      clip_right
);

   // Sum width large enough that CHANNELS full-scale words never overflow.
   localparam int unsigned SUM_W = AMP_W + $clog2(CHANNELS);
   localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'({AMP_W{1'b1}});

   // Per-channel state: counter, latched divisor, phase.
   logic [DIV_W-1:0]    r_cnt [CHANNELS];
   logic [DIV_W-1:0]    r_dl  [CHANNELS];
   logic [CHANNELS-1:0] r_ph;

   logic [CHANNELS-1:0] w_gate;
   logic [SUM_W-1:0]    w_sum_l;
   logic [SUM_W-1:0]    w_sum_r;
   logic                w_clip_l;
   logic                w_clip_r;
   logic [AMP_W-1:0]    w_sat_l;
   logic [AMP_W-1:0]    w_sat_r;

   // Channel divider state update.
   // A zero divisor reloads every cycle so a new value is picked up at once.
   // A nonzero divisor is reloaded only at terminal count, which keeps every
   // half-period whole when the note changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_cnt[i] <= '0;
            r_dl[i]  <= '0;
         end
         r_ph <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sync || (r_dl[i] == '0)) begin
               r_cnt[i] <= '0;
               r_ph[i]  <= 1'b0;
               r_dl[i]  <= note_div[i*DIV_W +: DIV_W];
            end else if (r_cnt[i] == r_dl[i]) begin
               r_cnt[i] <= '0;
               r_ph[i]  <= ~r_ph[i];
               r_dl[i]  <= note_div[i*DIV_W +: DIV_W];
            end else begin
               r_cnt[i] <= r_cnt[i] + DIV_W'(1);
            end
         end
      end
   end

   // A channel contributes during its low-phase-bit half when enabled and not silent.
   always_comb begin
      w_gate = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_gate[i] = ch_en[i] && (r_dl[i] != '0) && !r_ph[i];
      end
   end

   // Bus sums at full width.
   always_comb begin
      w_sum_l = '0;
      w_sum_r = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (w_gate[i] && left_mask[i]) begin
            w_sum_l = w_sum_l + SUM_W'(amp[i*AMP_W +: AMP_W]);
         end
         if (w_gate[i] && right_mask[i]) begin
            w_sum_r = w_sum_r + SUM_W'(amp[i*AMP_W +: AMP_W]);
         end
      end
   end

   // Saturate each bus to full scale and flag the clip.
   always_comb begin
      w_clip_l = (w_sum_l > MAX_SUM);
      w_clip_r = (w_sum_r > MAX_SUM);
      w_sat_l  = w_clip_l ? {AMP_W{1'b1}} : w_sum_l[AMP_W-1:0];
      w_sat_r  = w_clip_r ? {AMP_W{1'b1}} : w_sum_r[AMP_W-1:0];
   end

   // Registered sample outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         audio_left  <= '0;
         audio_right <= '0;
         clip_left   <= 1'b0;
         clip_right  <= 1'b0;
      end else begin
         audio_left  <= w_sat_l;
         audio_right <= w_sat_r;
         clip_left   <= w_clip_l;
         clip_right  <= w_clip_r;
      end
   end

endmodule

// File: tb/tb_tone_mixer.sv
// -----------------------------------------------------------------------------
// tb_tone_mixer
// Self-checking bench for tone_mixer (CHANNELS=4, DIV_W=20, AMP_W=16).
// A vector table drives channels 0/1 one clock edge per row and checks the
// registered outputs after that edge. Hand-written sequences then cover
// divisor change, zero divisor / enable, and asynchronous reset mid-tone.
// -----------------------------------------------------------------------------
module tb_tone_mixer;

   localparam int unsigned CH = 4;
   localparam int unsigned DW = 20;
   localparam int unsigned AW = 16;

   logic               clk;
   logic               rst_n;
   logic [CH*DW-1:0]   note_div;
   logic [CH*AW-1:0]   amp;
   logic [CH-1:0]      ch_en;
   logic [CH-1:0]      left_mask;
   logic [CH-1:0]      right_mask;
   logic               sync;
   logic [AW-1:0]      audio_left;
   logic [AW-1:0]      audio_right;
   logic               clip_left;
   logic               clip_right;

   int checks = 0;
   int errors = 0;

   tone_mixer #(.CHANNELS(CH), .DIV_W(DW), .AMP_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_div   (note_div),
      .amp        (amp),
      .ch_en      (ch_en),
      .left_mask  (left_mask),
      .right_mask (right_mask),
      .sync       (sync),
      .audio_left (audio_left),
      .audio_right(audio_right),
      .clip_left  (clip_left),
      .clip_right (clip_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic [DW-1:0] nd0;
      logic [DW-1:0] nd1;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [CH-1:0] en;
      logic [CH-1:0] lm;
      logic [CH-1:0] rm;
      logic          sy;
      logic [AW-1:0] el;
      logic [AW-1:0] er;
      logic          cl;
      logic          cr;
      string         nm;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic [DW-1:0] nd0, nd1,
                      input logic [AW-1:0] a0, a1, input logic [CH-1:0] en, lm, rm,
                      input logic sy, input logic [AW-1:0] el, er,
                      input logic cl, cr, input string nm);
      vec_t v;
      v.rst = rst; v.nd0 = nd0; v.nd1 = nd1; v.a0 = a0; v.a1 = a1;
      v.en = en; v.lm = lm; v.rm = rm; v.sy = sy;
      v.el = el; v.er = er; v.cl = cl; v.cr = cr; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic set_in(input logic [DW-1:0] nd0, nd1, input logic [AW-1:0] a0, a1,
                         input logic [CH-1:0] en, lm, rm, input logic sy);
      note_div = '0;
      amp      = '0;
      note_div[0  +: DW] = nd0;
      note_div[DW +: DW] = nd1;
      amp[0  +: AW] = a0;
      amp[AW +: AW] = a1;
      ch_en      = en;
      left_mask  = lm;
      right_mask = rm;
      sync       = sy;
   endtask

   task automatic chk(input logic [AW-1:0] el, er, input logic cl, cr, input string nm);
      checks++;
      if ({audio_left, audio_right, clip_left, clip_right} !== {el, er, cl, cr}) begin
         errors++;
         $display("FAIL %s: got L=%h R=%h cl=%b cr=%b, expected L=%h R=%h cl=%b cr=%b",
                  nm, audio_left, audio_right, clip_left, clip_right, el, er, cl, cr);
      end
   endtask

   // One clock edge, then check outputs 1 ns later.
   task automatic step(input logic [AW-1:0] el, er, input logic cl, cr, input string nm);
      @(posedge clk);
      #1;
      chk(el, er, cl, cr, nm);
   endtask

   // n edges expecting left=el, right=0, no clips.
   task automatic run_l(input int n, input logic [AW-1:0] el, input string nm);
      for (int k = 0; k < n; k++) step(el, 16'h0000, 1'b0, 1'b0, nm);
   endtask

   // Reset spanning one rising edge; release on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk(16'h0000, 16'h0000, 1'b0, 1'b0, "reset_state");
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in('0, '0, '0, '0, '0, '0, '0, 1'b0);

      // Single channel, divisor 3: E1 zero, then 4 high / 4 low.
      add(1, 3, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0000, 0, 0, 0, "single_E1");
      for (int k = 2; k <= 13; k++)
         add(0, 3, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 0,
             (((k - 2) / 4) % 2 == 0) ? 16'h1000 : 16'h0000, 0, 0, 0, "single_run");

      // Saturation: two 0xC000 channels on left, ch0 also on right, sync from reset.
      add(1, 5, 5, 16'hC000, 16'hC000, 4'b0011, 4'b0011, 4'b0001, 1, 0, 0, 0, 0, "sat_sync");
      for (int k = 2; k <= 14; k++) begin
         if (((k - 2) / 6) % 2 == 0)
            add(0, 5, 5, 16'hC000, 16'hC000, 4'b0011, 4'b0011, 4'b0001, 0,
                16'hFFFF, 16'hC000, 1, 0, "sat_high");
         else
            add(0, 5, 5, 16'hC000, 16'hC000, 4'b0011, 4'b0011, 4'b0001, 0,
                16'h0000, 16'h0000, 0, 0, "sat_low");
      end

      // Plain mixing without saturation.
      add(1, 3, 3, 16'h1000, 16'h2000, 4'b0011, 4'b0011, 4'b0010, 0, 0, 0, 0, 0, "mix_E1");
      add(0, 3, 3, 16'h1000, 16'h2000, 4'b0011, 4'b0011, 4'b0010, 0, 16'h3000, 16'h2000, 0, 0, "mix_E2");

      // Exactly full scale: no clip.
      add(1, 3, 3, 16'h8000, 16'h7FFF, 4'b0011, 4'b0011, 4'b0011, 0, 0, 0, 0, 0, "full_E1");
      add(0, 3, 3, 16'h8000, 16'h7FFF, 4'b0011, 4'b0011, 4'b0011, 0, 16'hFFFF, 16'hFFFF, 0, 0, "full_noclip");

      // One LSB over full scale: clip.
      add(1, 3, 3, 16'h8000, 16'h8000, 4'b0011, 4'b0011, 4'b0011, 0, 0, 0, 0, 0, "over_E1");
      add(0, 3, 3, 16'h8000, 16'h8000, 4'b0011, 4'b0011, 4'b0011, 0, 16'hFFFF, 16'hFFFF, 1, 1, "over_clip");

      // Sync coinciding with terminal count (divisor 1): sync wins, no toggle.
      add(1, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, "tc_E1");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0100, 0, 0, 0, "tc_E2");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 1, 16'h0100, 0, 0, 0, "tc_sync");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0100, 0, 0, 0, "tc_E4");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0100, 0, 0, 0, "tc_E5");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0000, 0, 0, 0, "tc_E6");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0000, 0, 0, 0, "tc_E7");
      add(0, 1, 0, 16'h0100, 0, 4'b0001, 4'b0001, 4'b0000, 0, 16'h0100, 0, 0, 0, "tc_E8");

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            set_in(tbl[i].nd0, tbl[i].nd1, tbl[i].a0, tbl[i].a1,
                   tbl[i].en, tbl[i].lm, tbl[i].rm, 1'b0);
            do_reset();
         end
         set_in(tbl[i].nd0, tbl[i].nd1, tbl[i].a0, tbl[i].a1,
                tbl[i].en, tbl[i].lm, tbl[i].rm, tbl[i].sy);
         step(tbl[i].el, tbl[i].er, tbl[i].cl, tbl[i].cr, tbl[i].nm);
      end

      // Divisor 9 -> 2 at cnt=4 of the first high phase.
      set_in(9, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
      do_reset();
      run_l(1, 16'h0000, "div_E1");
      run_l(4, 16'h1000, "div_high_a");
      set_in(2, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
      run_l(6, 16'h1000, "div_high_b");
      run_l(3, 16'h0000, "div_low3");
      run_l(3, 16'h1000, "div_high3");
      run_l(3, 16'h0000, "div_low3b");

      // Zero divisor stays silent; then divisor 1; then ch_en drop.
      set_in(0, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
      do_reset();
      run_l(8, 16'h0000, "zero_div");
      set_in(1, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
      run_l(1, 16'h0000, "nd1_load");
      run_l(2, 16'h1000, "nd1_high");
      run_l(2, 16'h0000, "nd1_low");
      run_l(2, 16'h1000, "nd1_high2");
      run_l(2, 16'h0000, "nd1_low2");
      set_in(1, 0, 16'h1000, 0, 4'b0000, 4'b0001, 4'b0000, 1'b0);
      run_l(3, 16'h0000, "en_off");
      set_in(1, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
      run_l(1, 16'h0000, "en_on_low");
      run_l(2, 16'h1000, "en_on_high");
      run_l(2, 16'h0000, "en_on_low2");

      // Asynchronous reset while the tone is high, then a clean restart.
      set_in(3, 0, 16'h1000, 0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
      do_reset();
      run_l(1, 16'h0000, "rst_E1");
      run_l(2, 16'h1000, "rst_pre_high");
      #2;
      rst_n = 1'b0;
      #1;
      chk(16'h0000, 16'h0000, 1'b0, 1'b0, "async_rst_zero");
      @(negedge clk);
      rst_n = 1'b1;
      run_l(1, 16'h0000, "restart_E1");
      run_l(4, 16'h1000, "restart_high");
      run_l(4, 16'h0000, "restart_low");
      run_l(4, 16'h1000, "restart_high2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
